rr_incr_arbiter: RTL and testbench

- Controller that shares one WIDTH-bit incrementer among NREQ requesters.
- Each requester owns a counter register held inside the block.
- The block arbitrates requests round-robin and sequences each update through a 3-state FSM (grant, compute, write-back).
- It is the scheduler for the counter datapath used across the session designs, and replaces per-register free-running increments with controlled, one-at-a-time updates.

---
 rtl/rr_incr_pkg.sv | 21 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_incr_arbiter.sv | 118 +++++++++++
 tb/tb_rr_incr_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rr_incr_pkg.sv
// rtl/rr_incr_pkg.sv - shared types, defaults and helpers for the round-robin incrementer
package rr_incr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int DEF_NREQ  = 2;
    localparam int DEF_WIDTH = 4;

    // Index width for n requesters; clamped to 1 so a 1-bit index always exists.
    function automatic int clog2(input int n);
        int w;
        for (w = 1; (1 << w) < n; w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req     - per-requester request vector
//   ptr     - highest-priority index
//   winner  - first requesting index at or after ptr (modulo NREQ)
//   any_req - at least one request is pending
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rr_incr_arbiter.sv
// rtl/rr_incr_arbiter.sv - round-robin scheduler sharing one incrementer across NREQ counters
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   req      - per-requester increment request (level, held until ack)
//   gnt      - registered one-hot grant
//   ack      - one-hot, high in the cycle the update commits
//   wrap     - one-hot, high with ack when the count overflowed
//   cnt_flat - all counters, counter i at [i*WIDTH +: WIDTH]
//   busy     - FSM not idle
//
// Build option: RR_INCR_SATURATE_EN makes counters saturate at all-ones
// (wrap then acts as a saturation flag) instead of rolling over.
module rr_incr_arbiter
    import rr_incr_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       wrap,
    output logic [NREQ*WIDTH-1:0] cnt_flat,
    output logic                  busy
);

    localparam int IW = clog2(NREQ);

    state_t           state, state_n;
    logic [IW-1:0]    sel, ptr, ptr_n, winner;
    logic             any_req;
    logic [WIDTH:0]   sum_q, sum_n;
    logic [WIDTH-1:0] wb_val;
    logic [WIDTH-1:0] cnt [NREQ];

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        ack     = '0;
        wrap    = '0;
        case (state)
            IDLE:  if (any_req) state_n = GRANT;
            GRANT: state_n = WRITE;
            WRITE: begin
                state_n   = IDLE;
                ack[sel]  = 1'b1;
                wrap[sel] = sum_q[WIDTH];
            end
            default: state_n = IDLE;
        endcase
    end

    // The single shared adder; the extra MSB carries the overflow into WRITE.
    assign sum_n = {1'b0, cnt[sel]} + (WIDTH+1)'(1);
    assign ptr_n = (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;

`ifdef RR_INCR_SATURATE_EN
    assign wb_val = sum_q[WIDTH] ? '1 : sum_q[WIDTH-1:0];
`else
    assign wb_val = sum_q[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel   <= '0;
            ptr   <= '0;
            gnt   <= '0;
            sum_q <= '0;
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel <= winner;
                        gnt <= NREQ'(1) << winner;
                    end else begin
                        gnt <= '0;
                    end
                end
                GRANT: sum_q <= sum_n;
                WRITE: begin
                    cnt[sel] <= wb_val;
                    ptr      <= ptr_n;
                    gnt      <= '0;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_flat
        assign cnt_flat[g*WIDTH +: WIDTH] = cnt[g];
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rr_incr_arbiter.sv
// tb/tb_rr_incr_arbiter.sv - scoreboard bench for rr_incr_arbiter
module tb_rr_incr_arbiter;

    localparam int NREQ  = 2;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       gnt, ack, wrap;
    logic [NREQ*WIDTH-1:0] cnt_flat;
    logic                  busy;

    typedef struct {
        int idx;
        bit wrp;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rr_incr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .ack      (ack),
        .wrap     (wrap),
        .cnt_flat (cnt_flat),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cnt_of(input int i);
        return int'(cnt_flat[i*WIDTH +: WIDTH]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input bit wrp, input int cnt);
        exp_t e;
        e.idx = idx;
        e.wrp = wrp;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        check("pending_acks", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (|ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", int'(ack), 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_onehot", int'(ack), 1 << e.idx);
                    check("ack_gnt", int'(gnt), 1 << e.idx);
                    check("wrap", int'(wrap), e.wrp ? (1 << e.idx) : 0);
                    @(posedge clk);
                    #1;
                    check("cnt_after_commit", cnt_of(e.idx), e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_upd;

        // Reset state
        do_reset();
        check("reset_cnt_flat", int'(cnt_flat), 0);
        check("reset_gnt", int'(gnt), 0);
        check("reset_ack", int'(ack), 0);
        check("reset_busy", int'(busy), 0);

        // Single requester: 15 cycles -> 5 commits
        for (int k = 1; k <= 5; k++) push(0, 1'b0, k);
        req = 2'b01;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (gnt == 2'b10) check("single_no_gnt1", int'(gnt), 1);
        end
        req = 2'b00;
        drain();
        check("single_cnt0", cnt_of(0), 5);
        check("single_cnt1", cnt_of(1), 0);

        // Contention from ptr=0: order 0,1,0,1
        do_reset();
        push(0, 1'b0, 1);
        push(1, 1'b0, 1);
        push(0, 1'b0, 2);
        push(1, 1'b0, 2);
        req = 2'b11;
        for (int c = 0; c < 12; c++) tick();
        req = 2'b00;
        drain();
        check("contend_cnt0", cnt_of(0), 2);
        check("contend_cnt1", cnt_of(1), 2);

        // Wrap / saturate on requester 1
        do_reset();
`ifdef RR_INCR_SATURATE_EN
        n_upd = 17;
        for (int k = 1; k <= n_upd; k++) push(1, k >= 16, (k > 15) ? 15 : k);
`else
        n_upd = 16;
        for (int k = 1; k <= n_upd; k++) push(1, k == 16, k % 16);
`endif
        req = 2'b10;
        for (int c = 0; c < 3 * n_upd; c++) tick();
        req = 2'b00;
        drain();
`ifdef RR_INCR_SATURATE_EN
        check("sat_cnt1", cnt_of(1), 15);
`else
        check("wrap_cnt1", cnt_of(1), 0);
`endif
        check("wrap_cnt0", cnt_of(0), 0);

        // Reset while requester 0 is in GRANT: update discarded
        do_reset();
        req = 2'b01;
        tick();
        check("midop_busy", int'(busy), 1);
        check("midop_gnt", int'(gnt), 1);
        rst = 1'b1;
        req = 2'b00;
        #1;
        check("midop_rst_busy", int'(busy), 0);
        check("midop_rst_gnt", int'(gnt), 0);
        tick();
        tick();
        rst = 1'b0;
        check("midop_cnt0", cnt_of(0), 0);

        // ptr back at 0, and req dropped during GRANT still commits once
        req = 2'b11;
        tick();
        check("ptr0_gnt", int'(gnt), 1);
        req = 2'b00;
        push(0, 1'b0, 1);
        tick();
        tick();
        tick();
        drain();
        check("drop_gnt", int'(gnt), 0);
        check("drop_busy", int'(busy), 0);
        check("drop_cnt0", cnt_of(0), 1);
        check("drop_cnt1", cnt_of(1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
